snake_step_scheduler: RTL and testbench
=======================================

Name: snake_step_scheduler

Overview:
- Sequences game-logic updates against the VGA raster and arbitrates the shared game-state memory between the pixel renderer and the snake logic.
- Renderer owns the memory during the frame. Once every N frames, in vertical blanking, logic gets a bounded step window through a req/done handshake.
- Consumes the raster counters (xCount, yCount) of the VGA timing generator; same clock domain.

Parameters:
- VBLANK_START_LINE, 480, first non-visible line; step window opens at its pixel 0
- DEADLINE_LINE, 522, line whose pixel 0 closes the step window
- SPEED_W, 6, width of speed input

Ports:
- VGA_clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- xCount  in  10  horizontal raster count
- yCount  in  10  vertical raster count
- speed  in  SPEED_W  frames per step; 0 treated as 1
- pause  in  1  freeze frame counting; no steps issued
- clr_overrun  in  1  clears overrun flag
- step_done  in  1  logic finished step (pulse or level)
- step_req  out  1  logic may perform one update
- step_abort  out  1  1-cycle pulse: window closed before done
- logic_grant  out  1  logic owns game-state memory
- render_grant  out  1  renderer owns game-state memory
- frame_tick  out  1  1-cycle pulse per frame at vblank entry
- overrun  out  1  sticky: a step was aborted

Behaviour:
- Events:
  - vb_start = (yCount==VBLANK_START_LINE && xCount==0)
  - deadline = (yCount==DEADLINE_LINE && xCount==0)
  - Both are decoded combinationally and acted on at that edge.
- frame_tick is registered high for exactly the cycle after vb_start.
- Reset: state RENDER, render_grant=1, all other outputs 0, frame_cnt=0.
- All outputs are registered and Moore-decoded from state. Grants are never both 1.
- eff_speed = (speed==0) ? 1 : speed. It is sampled only at vb_start.
- States:
  - RENDER: render_grant=1. On vb_start:
    - If pause: frame_cnt holds.
    - Else if frame_cnt+1 >= eff_speed: frame_cnt<=0, go to GAP.
    - Else: frame_cnt++.
  - GAP: both grants 0, for 1 cycle (bus turnaround); then go to STEP.
  - STEP: logic_grant=1, step_req=1.
    - step_done sampled 1 goes to RETURN.
    - deadline without step_done: step_abort=1 for 1 cycle, overrun<=1, go to RETURN.
    - step_done and deadline in the same cycle: done wins, no abort, no overrun.
  - RETURN: both grants 0, step_req=0, for 1 cycle; then go to RENDER.
- Latency:
  - vb_start edge to logic_grant/step_req high: 2 cycles.
  - step_done edge to render_grant high: 2 cycles.
- step_done outside STEP is ignored.
- Speed reduced below frame_cnt+1 mid-count: a step is issued at the next unpaused vb_start.
- A step is issued at most once per frame. vb_start seen outside RENDER is ignored for counting.
- overrun is cleared by reset or clr_overrun. Setting (abort) wins over a simultaneous clear.
- Pause asserted during STEP does not cut the step short.
- Reset mid-STEP: immediate return to the reset state. step_req drops on the next edge.

Optional Feature:
- Macro: SNAKE_SCHED_STATS_EN.
- Defined:
  - Adds outputs step_count[15:0] (increments on each RETURN entry after a done) and abort_count[7:0] (increments per abort, saturates at 255).
  - Both reset to 0.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package snake_sched_pkg:
  - State encoding (RENDER, GAP, STEP, RETURN).
  - Raster constants: visible 640x480, line total 794, frame total 526.
  - Default VBLANK_START_LINE / DEADLINE_LINE.
- Sub-module vga_line_event:
  - Decodes vb_start/deadline from xCount/yCount.
  - Registers frame_tick.
  - Reused by other blanking-synchronised blocks.

Test Plan:
- speed=4, pause=0, step_done returned 10 cycles after step_req -> step_req once every 4th frame_tick; logic_grant high 2 cycles after vb_start; render_grant back 2 cycles after done.
- speed=0 -> behaves as speed=1; a step every frame; step_count (stats) = frames elapsed.
- step_done never asserted -> at y=522,x=0: step_abort 1-cycle pulse, overrun=1, render_grant restored 2 cycles later; clr_overrun clears it.
- step_done pulsed at y=522,x=0 exactly -> no abort, overrun stays 0.
- pause=1 across 5 frames with speed=2 -> no step_req, frame_cnt frozen; release -> step at next qualifying vb_start.
- reset asserted in STEP -> next edge: logic_grant=0, render_grant=1, step_req=0, frame_cnt=0; grants never both 1 throughout (assertion).

Source files
------------

// File: rtl/snake_sched_pkg.sv
// Shared definitions for the snake step scheduler: FSM state encoding,
// VGA raster geometry and the default blanking line numbers.
package snake_sched_pkg;

   // 640x480 visible area inside a 794-pixel line and a 526-line frame.
   localparam int H_VISIBLE = 640;
   localparam int V_VISIBLE = 480;
   localparam int H_TOTAL   = 794;
   localparam int V_TOTAL   = 526;

   // The step window opens at the first non-visible line and closes at the
   // deadline line, leaving a few lines for the renderer to prefetch.
   localparam int VBLANK_START_LINE_DEF = V_VISIBLE;
   localparam int DEADLINE_LINE_DEF     = 522;

   // Scheduler states, kept as plain constants so older tools can use them.
   localparam logic [1:0] ST_RENDER = 2'd0;
   localparam logic [1:0] ST_GAP    = 2'd1;
   localparam logic [1:0] ST_STEP   = 2'd2;
   localparam logic [1:0] ST_RETURN = 2'd3;

   // Memory-ownership outputs that depend only on the state.
   typedef struct packed {
      logic step_req;
      logic logic_grant;
      logic render_grant;
   } grant_t;

   // Moore decode: the renderer owns memory only in RENDER, the logic only
   // in STEP; GAP and RETURN are turnaround cycles where nobody owns it.
   function automatic grant_t decode_state(input logic [1:0] st);
      grant_t g;
      g.step_req     = (st == ST_STEP);
      g.logic_grant  = (st == ST_STEP);
      g.render_grant = (st == ST_RENDER);
      return g;
   endfunction

endpackage

// File: rtl/vga_line_event.sv
// Decodes the vertical-blanking entry and deadline events from the raster
// counters and produces a registered one-cycle frame tick. Shared by any
// block that has to synchronise to blanking.
module vga_line_event
   import snake_sched_pkg::*;
#(
   parameter int VBLANK_START_LINE = VBLANK_START_LINE_DEF,
   parameter int DEADLINE_LINE     = DEADLINE_LINE_DEF
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [9:0] x_count_i,
   input  logic [9:0] y_count_i,
   output logic       vb_start_o,
   output logic       deadline_o,
   output logic       frame_tick_o
);

   logic frame_tick_q;

   // Events are combinational so the FSM acts on the very edge they occur.
   assign vb_start_o = (y_count_i == 10'(VBLANK_START_LINE)) && (x_count_i == 10'd0);
   assign deadline_o = (y_count_i == 10'(DEADLINE_LINE))     && (x_count_i == 10'd0);

   // Frame tick is high for exactly the cycle after vblank entry.
   always_ff @(posedge clk_i) begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples pre-edge values, independent of block evaluation order.
      if (reset_i) frame_tick_q <= 1'b0;
      else         frame_tick_q <= vb_start_o;
   end

   assign frame_tick_o = frame_tick_q;

endmodule

// File: rtl/snake_step_scheduler.sv
// Snake step scheduler: arbitrates the game-state memory between the pixel
// renderer and the snake logic. Every eff_speed frames, at vblank entry, the
// logic is handed a step window that closes at the deadline line.
// Optional build macro SNAKE_SCHED_STATS_EN adds step/abort counters.
module snake_step_scheduler
   import snake_sched_pkg::*;
#(
   parameter int VBLANK_START_LINE = VBLANK_START_LINE_DEF,
   parameter int DEADLINE_LINE     = DEADLINE_LINE_DEF,
   parameter int SPEED_W           = 6
) (
   input  logic               VGA_clk,
   input  logic               reset,
   input  logic [9:0]         xCount,
   input  logic [9:0]         yCount,
   input  logic [SPEED_W-1:0] speed,
   input  logic               pause,
   input  logic               clr_overrun,
   input  logic               step_done,
   output logic               step_req,
   output logic               step_abort,
   output logic               logic_grant,
   output logic               render_grant,
   output logic               frame_tick,
   output logic               overrun
`ifdef SNAKE_SCHED_STATS_EN
  ,output logic [15:0]        step_count
  ,output logic [7:0]         abort_count
`endif
);

   logic               vb_start;
   logic               deadline;

   logic [1:0]         state_q, state_d;
   logic [SPEED_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [SPEED_W-1:0] eff_speed;
   logic               abort_d;
   logic               done_d;

   grant_t             grant_q;
   logic               step_abort_q;
   logic               overrun_q;

   vga_line_event #(
      .VBLANK_START_LINE (VBLANK_START_LINE),
      .DEADLINE_LINE     (DEADLINE_LINE)
   ) u_line_event (
      .clk_i        (VGA_clk),
      .reset_i      (reset),
      .x_count_i    (xCount),
      .y_count_i    (yCount),
      .vb_start_o   (vb_start),
      .deadline_o   (deadline),
      .frame_tick_o (frame_tick)
   );

   // A speed of zero would never fire, so it is treated as one frame per step.
   assign eff_speed = (speed == '0) ? SPEED_W'(1) : speed;

   // Next-state logic: frame counting in RENDER, handshake in STEP.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // it unassigned, which would otherwise infer a latch.
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      abort_d     = 1'b0;
      done_d      = 1'b0;
      case (state_q)
         ST_RENDER: begin
            if (vb_start && !pause) begin
               // >= rather than == so a speed lowered mid-count fires next frame.
               if (({1'b0, frame_cnt_q} + 1'b1) >= {1'b0, eff_speed}) begin
                  frame_cnt_d = '0;
                  state_d     = ST_GAP;
               end else begin
                  frame_cnt_d = frame_cnt_q + 1'b1;
               end
            end
         end
         ST_GAP:    state_d = ST_STEP;
         ST_STEP: begin
            // Done is checked first so it wins over a coincident deadline.
            if (step_done) begin
               done_d  = 1'b1;
               state_d = ST_RETURN;
            end else if (deadline) begin
               abort_d = 1'b1;
               state_d = ST_RETURN;
            end
         end
         ST_RETURN: state_d = ST_RENDER;
         default:   state_d = ST_RENDER;
      endcase
   end

   // State, frame counter and registered Moore outputs.
   always_ff @(posedge VGA_clk) begin
      if (reset) begin
         state_q      <= ST_RENDER;
         frame_cnt_q  <= '0;
         grant_q      <= '{step_req: 1'b0, logic_grant: 1'b0, render_grant: 1'b1};
         step_abort_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         frame_cnt_q  <= frame_cnt_d;
         grant_q      <= decode_state(state_q);
         step_abort_q <= abort_d;
         if (abort_d)          overrun_q <= 1'b1;
         else if (clr_overrun) overrun_q <= 1'b0;
      end
   end

   assign step_req     = grant_q.step_req;
   assign logic_grant  = grant_q.logic_grant;
   assign render_grant = grant_q.render_grant;
   assign step_abort   = step_abort_q;
   assign overrun      = overrun_q;

`ifdef SNAKE_SCHED_STATS_EN
   logic [15:0] step_count_q;
   logic [7:0]  abort_count_q;

   // Completed and aborted step counters; the abort count saturates.
   always_ff @(posedge VGA_clk) begin
      if (reset) begin
         step_count_q  <= '0;
         abort_count_q <= '0;
      end else begin
         if (done_d) step_count_q <= step_count_q + 16'd1;
         if (abort_d && (abort_count_q != 8'hFF)) abort_count_q <= abort_count_q + 8'd1;
      end
   end

   assign step_count  = step_count_q;
   assign abort_count = abort_count_q;
`endif

endmodule

// File: tb/tb_snake_step_scheduler.sv
// Self-checking bench for snake_step_scheduler. Drives a compressed raster
// (only the event coordinates matter) with randomized speed, pause, done
// timing and overrun clears, and compares every output each cycle against a
// timeline model of step windows.
module tb_snake_step_scheduler;

   localparam int SW        = 6;
   localparam int FRAME_LEN = 40;
   localparam int DL_OFF    = 30;  // deadline position relative to vb_start

   logic          VGA_clk = 1'b0;
   logic          reset = 1'b1;
   logic [9:0]    xCount = 10'd0;
   logic [9:0]    yCount = 10'd0;
   logic [SW-1:0] speed = '0;
   logic          pause = 1'b0;
   logic          clr_overrun = 1'b0;
   logic          step_done = 1'b0;
   logic          step_req, step_abort, logic_grant, render_grant, frame_tick, overrun;
`ifdef SNAKE_SCHED_STATS_EN
   logic [15:0]   step_count;
   logic [7:0]    abort_count;
`endif

   always #5 VGA_clk = ~VGA_clk;

   snake_step_scheduler #(.SPEED_W(SW)) dut (
      .VGA_clk      (VGA_clk),
      .reset        (reset),
      .xCount       (xCount),
      .yCount       (yCount),
      .speed        (speed),
      .pause        (pause),
      .clr_overrun  (clr_overrun),
      .step_done    (step_done),
      .step_req     (step_req),
      .step_abort   (step_abort),
      .logic_grant  (logic_grant),
      .render_grant (render_grant),
      .frame_tick   (frame_tick),
      .overrun      (overrun)
`ifdef SNAKE_SCHED_STATS_EN
     ,.step_count   (step_count)
     ,.abort_count  (abort_count)
`endif
   );

   grants_exclusive : assert property (@(posedge VGA_clk) !(logic_grant && render_grant));

   int errors = 0;
   int checks = 0;
   int k = 0;            // index of the most recent clock edge

   // Reference model: a step is a window [issue edge, end edge].
   int m_cnt = 0, m_issue = -100, m_end = -100, m_vb = -100;
   bit m_in_step = 0, m_aborted = 0, m_ovr = 0;
   int m_steps = 0, m_aborts = 0;

   // Stimulus plan for step_done.
   int done_mode = 0, done_from = -1, done_to = -2;
   bit spurious_en = 0;
   int clr_at_off = -1;
   bit clr_random = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0d, expected %0d", tag, k, obs, exp);
      end
   endtask

   task automatic plan_done(input int e_issue);
      case (done_mode)
         0: begin done_from = e_issue + 12; done_to = done_from; end
         1: begin
            done_from = e_issue + 2 + $urandom_range(0, 35);
            done_to   = done_from + $urandom_range(0, 2);
         end
         2: begin done_from = -1; done_to = -2; end
         default: begin done_from = e_issue + DL_OFF; done_to = done_from; end
      endcase
   endtask

   // Apply the behavioural rules to the inputs present at edge k.
   task automatic model_edge();
      bit vb, dl, ended_abort, idle;
      int eff;
      vb = (yCount == 10'd480) && (xCount == 10'd0);
      dl = (yCount == 10'd522) && (xCount == 10'd0);
      ended_abort = 0;
      if (reset) begin
         m_cnt = 0; m_issue = -100; m_end = -100; m_vb = -100;
         m_in_step = 0; m_aborted = 0; m_ovr = 0; m_steps = 0; m_aborts = 0;
         done_from = -1; done_to = -2;
         return;
      end
      if (m_in_step && k >= m_issue + 2) begin
         if (step_done) begin
            m_end = k; m_in_step = 0; m_aborted = 0; m_steps++;
         end else if (dl) begin
            m_end = k; m_in_step = 0; m_aborted = 1; m_ovr = 1; ended_abort = 1;
            if (m_aborts < 255) m_aborts++;
         end
      end
      if (clr_overrun && !ended_abort) m_ovr = 0;
      if (vb) begin
         m_vb = k;
         idle = !m_in_step && (k >= m_end + 2);
         if (idle && !pause) begin
            eff = (speed == 0) ? 1 : int'(speed);
            if (m_cnt + 1 >= eff) begin
               m_cnt = 0; m_issue = k; m_in_step = 1;
               plan_done(k);
            end else begin
               m_cnt++;
            end
         end
      end
   endtask

   task automatic compare_all();
      bit lg, rg, ab;
      lg = (k >= m_issue + 2) && (m_in_step || k <= m_end);
      rg = !((k >= m_issue + 1) && (m_in_step || k <= m_end + 1));
      ab = !m_in_step && m_aborted && (m_end == k);
      check("logic_grant",  logic_grant,  lg);
      check("step_req",     step_req,     lg);
      check("render_grant", render_grant, rg);
      check("step_abort",   step_abort,   ab);
      check("frame_tick",   frame_tick,   m_vb == k);
      check("overrun",      overrun,      m_ovr);
      check("grants_excl",  logic_grant && render_grant, 1'b0);
`ifdef SNAKE_SCHED_STATS_EN
      check("step_count",   step_count,   m_steps);
      check("abort_count",  abort_count,  m_aborts);
`endif
   endtask

   task automatic tick();
      @(posedge VGA_clk);
      k++;
      model_edge();
      #1;
      compare_all();
   endtask

   // Set raster and control inputs for the next edge, then clock it.
   task automatic frame_cycle(input int off);
      int e;
      case (off)
         0:             begin yCount = 10'd480; xCount = 10'd0; end
         1:             begin yCount = 10'd480; xCount = 10'd1; end
         DL_OFF:        begin yCount = 10'd522; xCount = 10'd0; end
         DL_OFF + 1:    begin yCount = 10'd522; xCount = 10'd1; end
         FRAME_LEN - 1: begin yCount = 10'd479; xCount = 10'd0; end
         default: begin
            if (off < DL_OFF) yCount = 10'($urandom_range(481, 521));
            else              yCount = 10'($urandom_range(0, 478));
            xCount = 10'($urandom_range(0, 793));
         end
      endcase
      e = k + 1;
      step_done   = ((e >= done_from) && (e <= done_to)) ||
                    (spurious_en && ($urandom_range(0, 15) == 0));
      clr_overrun = (off == clr_at_off) || (clr_random && ($urandom_range(0, 19) == 0));
      tick();
   endtask

   task automatic run_frames(input int n);
      for (int f = 0; f < n; f++)
         for (int off = 0; off < FRAME_LEN; off++) frame_cycle(off);
   endtask

   initial begin
      // Reset state.
      reset = 1'b1;
      tick();
      tick();
      check("reset_render_grant", render_grant, 1'b1);
      reset = 1'b0;
      tick();

      // Regular cadence: speed 4, done 10 cycles after step_req.
      speed = 6'd4; done_mode = 0;
      run_frames(9);

      // Speed 0 behaves as speed 1: a step every frame.
      speed = 6'd0; done_mode = 1; spurious_en = 1;
      run_frames(5);

      // Done never arrives: abort and sticky overrun, then clear it.
      speed = 6'd1; done_mode = 2; spurious_en = 0;
      run_frames(2);
      clr_at_off = 35;
      run_frames(1);
      clr_at_off = -1;

      // Done lands exactly on the deadline edge: no abort.
      done_mode = 3;
      run_frames(3);

      // Pause over five frames with speed 2, then release.
      speed = 6'd2; done_mode = 0; pause = 1'b1;
      run_frames(5);
      pause = 1'b0;
      run_frames(3);

      // Randomized mix, including speed changes mid-count and pause in STEP.
      spurious_en = 1; clr_random = 1;
      for (int f = 0; f < 30; f++) begin
         speed     = SW'($urandom_range(0, 5));
         pause     = ($urandom_range(0, 3) == 0);
         done_mode = $urandom_range(0, 3);
         for (int off = 0; off < FRAME_LEN; off++) begin
            if (off == 15) pause = $urandom_range(0, 1);
            frame_cycle(off);
         end
      end
      pause = 1'b0; spurious_en = 0; clr_random = 0;

      // Reset in the middle of a step, then confirm the frame count restarted.
      speed = 6'd1; done_mode = 2;
      for (int off = 0; off < 10; off++) frame_cycle(off);
      reset = 1'b1;
      frame_cycle(10);
      check("rst_step_req", step_req, 1'b0);
      check("rst_render_grant", render_grant, 1'b1);
      reset = 1'b0;
      for (int off = 11; off < FRAME_LEN; off++) frame_cycle(off);
      speed = 6'd3; done_mode = 0;
      run_frames(4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
